// File: rtl/fifo_uart_tx_if.sv
// Bundle of signals between the byte FIFO and the UART transmit stage.
// The FIFO read handshake is a plain strobe. The transmitter raises
// fifo_rd_en for one clk only while fifo_empty is low. The FIFO advances
// at that edge and presents the byte on fifo_dout during the following
// cycle. There is no ready/stall path back from the FIFO.
interface fifo_uart_tx_if;
    logic       fifo_empty;
    logic [7:0] fifo_dout;
    logic       fifo_rd_en;
    logic       tx;
    logic       busy;
    logic       tx_done;

    // Transmitter side: consumes FIFO status/data and drives the line.
    modport master (
        input  fifo_empty,
        input  fifo_dout,
        output fifo_rd_en,
        output tx,
        output busy,
        output tx_done
    );

    // FIFO/environment side.
    modport slave (
        output fifo_empty,
        output fifo_dout,
        input  fifo_rd_en,
        input  tx,
        input  busy,
        input  tx_done
    );
endinterface

// File: rtl/fifo_uart_tx.sv
// UART transmit stage that pulls one byte per frame from a registered-output
// FIFO and sends start, 8 data bits LSB-first, optional parity and stop.
// The FSM state is exported on state_o for observation.
module fifo_uart_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0
) (
    input  logic           clk,
    input  logic           rst,
    fifo_uart_tx_if.master uart_io,
    output logic [2:0]     state_o
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        WAIT   = 3'd2,
        START  = 3'd3,
        DATA   = 3'd4,
        PARITY = 3'd5,
        STOP   = 3'd6
    } state_t;

    localparam logic [15:0] CNT_LAST = 16'(CLKS_PER_BIT - 1);
    localparam logic        ODD_BIT  = (PARITY_ODD != 0);

    state_t      state_q, state_d;
    logic [15:0] cnt_q,   cnt_d;
    logic [2:0]  bit_q,   bit_d;
    logic [7:0]  shift_q, shift_d;
    logic        par_q,   par_d;
    logic        tx_q,    tx_d;
    logic        done_q,  done_d;
    logic        bit_end;

    assign bit_end = (cnt_q == CNT_LAST);

    // State and datapath registers; reset drives the line idle high at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
            done_q  <= done_d;
        end
    end

    // Next-state logic: tx is computed one cycle ahead so the line is a flop.
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        bit_d   = bit_q;
        shift_d = shift_q;
        par_d   = par_q;
        tx_d    = tx_q;
        done_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (!uart_io.fifo_empty) begin
                    state_d = FETCH;
                end
            end
            FETCH: begin
                state_d = WAIT;
            end
            WAIT: begin
                // Registered FIFO data is valid only in this cycle.
                shift_d = uart_io.fifo_dout;
                par_d   = (^uart_io.fifo_dout) ^ ODD_BIT;
                bit_d   = 3'd0;
                tx_d    = 1'b0;
                state_d = START;
            end
            START: begin
                cnt_d = bit_end ? 16'd0 : cnt_q + 16'd1;
                if (bit_end) begin
                    tx_d    = shift_q[0];
                    state_d = DATA;
                end
            end
            DATA: begin
                cnt_d = bit_end ? 16'd0 : cnt_q + 16'd1;
                if (bit_end) begin
                    if (bit_q == 3'd7) begin
                        if (PARITY_EN != 0) begin
                            tx_d    = par_q;
                            state_d = PARITY;
                        end else begin
                            tx_d    = 1'b1;
                            state_d = STOP;
                        end
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        shift_d = {1'b0, shift_q[7:1]};
                        tx_d    = shift_q[1];
                    end
                end
            end
            PARITY: begin
                cnt_d = bit_end ? 16'd0 : cnt_q + 16'd1;
                if (bit_end) begin
                    tx_d    = 1'b1;
                    state_d = STOP;
                end
            end
            STOP: begin
                cnt_d = bit_end ? 16'd0 : cnt_q + 16'd1;
                if (bit_end) begin
                    done_d  = 1'b1;
                    tx_d    = 1'b1;
                    state_d = uart_io.fifo_empty ? IDLE : FETCH;
                end
            end
            default: begin
                tx_d    = 1'b1;
                state_d = IDLE;
            end
        endcase
    end

    assign uart_io.fifo_rd_en = (state_q == FETCH);
    assign uart_io.busy       = (state_q != IDLE);
    assign uart_io.tx         = tx_q;
    assign uart_io.tx_done    = done_q;
    assign state_o            = state_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: four instances with different bit widths and parity
// settings, each fed by a behavioural FIFO and compared every cycle against a
// waveform-level model of the serial frame, plus directed literal checks.
module tb_fifo_uart_tx;

    localparam int NI = 4;

    typedef struct packed {
        logic tx;
        logic busy;
        logic rd;
        logic done;
        logic last;
    } cyc_t;

    localparam cyc_t IDLE_C = '{tx: 1'b1, busy: 1'b0, rd: 1'b0, done: 1'b0, last: 1'b0};

    logic clk;
    logic rst;

    int checks = 0;
    int errors = 0;

    logic [7:0] fq [NI][$];
    logic       emp [NI] = '{1'b1, 1'b1, 1'b1, 1'b1};
    int         rd_cnt [NI] = '{0, 0, 0, 0};
    logic       tx_w [NI];
    logic       busy_w [NI];
    logic       rd_w [NI];
    logic       done_w [NI];
    logic [2:0] st_w [NI];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic bit_at(input logic [7:0] d, input int b, input int pen, input int odd);
        if (b == 0) return 1'b0;
        if (b <= 8) return d[b-1];
        if (pen != 0 && b == 9) return (^d) ^ (odd != 0);
        return 1'b1;
    endfunction

    for (genvar I = 0; I < NI; I++) begin : g_inst
        localparam int CPB = (I == 3) ? 2 : 4;
        localparam int PEN = (I == 1 || I == 2) ? 1 : 0;
        localparam int POD = (I == 2) ? 1 : 0;

        fifo_uart_tx_if ifc ();

        fifo_uart_tx #(
            .CLKS_PER_BIT(CPB),
            .PARITY_EN   (PEN),
            .PARITY_ODD  (POD)
        ) dut (
            .clk    (clk),
            .rst    (rst),
            .uart_io(ifc),
            .state_o(st_w[I])
        );

        assign ifc.fifo_empty = emp[I];
        assign tx_w[I]   = ifc.tx;
        assign busy_w[I] = ifc.busy;
        assign rd_w[I]   = ifc.fifo_rd_en;
        assign done_w[I] = ifc.tx_done;

        // Behavioural FIFO: registered data after a read, junk otherwise.
        logic rd_s;
        initial ifc.fifo_dout = 8'h00;
        always begin
            @(negedge clk);
            rd_s = ifc.fifo_rd_en;
            @(posedge clk);
            #1;
            if (rd_s) begin
                checks++;
                if (fq[I].size() == 0) begin
                    errors++;
                    $display("FAIL rd_on_empty inst%0d t=%0t: read with %0d bytes, required at least 1", I, $time, fq[I].size());
                    ifc.fifo_dout = 8'($urandom);
                end else begin
                    ifc.fifo_dout = fq[I].pop_front();
                end
                rd_cnt[I]++;
            end else begin
                ifc.fifo_dout = 8'($urandom);
            end
            emp[I] = (fq[I].size() == 0);
        end

        // Expected-waveform model and per-cycle compare.
        cyc_t wave_q[$];
        cyc_t cur = IDLE_C;
        logic pend = 1'b0;
        always @(negedge clk) begin
            cyc_t nxt;
            logic [3:0] act;
            logic [3:0] expv;
            logic [7:0] d;
            if (!rst) begin
                wave_q.delete();
                pend = 1'b0;
                cur  = IDLE_C;
            end
            act  = {ifc.tx, ifc.busy, ifc.fifo_rd_en, ifc.tx_done};
            expv = {cur.tx, cur.busy, cur.rd, cur.done};
            checks++;
            if (act !== expv) begin
                errors++;
                $display("FAIL cycle inst%0d t=%0t: tx/busy/rd/done got %b required %b", I, $time, act, expv);
            end
            if (rst) begin
                if (wave_q.size() != 0) begin
                    nxt  = wave_q.pop_front();
                    pend = nxt.last;
                end else begin
                    nxt = IDLE_C;
                    nxt.done = pend;
                    pend = 1'b0;
                    if (!emp[I]) begin
                        d = fq[I][0];
                        nxt.busy = 1'b1;
                        nxt.rd   = 1'b1;
                        wave_q.push_back('{tx: 1'b1, busy: 1'b1, rd: 1'b0, done: 1'b0, last: 1'b0});
                        for (int b = 0; b < 10 + PEN; b++) begin
                            for (int k = 0; k < CPB; k++) begin
                                wave_q.push_back('{tx: bit_at(d, b, PEN, POD), busy: 1'b1, rd: 1'b0,
                                                   done: 1'b0, last: (b == 9 + PEN) && (k == CPB - 1)});
                            end
                        end
                    end
                end
                cur = nxt;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s t=%0t: got %0h required %0h", name, $time, act, expv);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s t=%0t: timed out waiting for DUT", name, $time);
    endtask

    task automatic wr(input int inst, input logic [7:0] b);
        fq[inst].push_back(b);
    endtask

    // Call on a negedge; returns on the negedge of the tx_done cycle.
    task automatic capture(input int inst, input int cpb, input int nb,
                           output logic [10:0] bits, output int len, output int gap);
        logic line [256];
        int c;
        bits = '0;
        len  = 0;
        gap  = 0;
        while (tx_w[inst] !== 1'b0 && gap < 400) begin
            @(negedge clk);
            gap++;
        end
        if (gap >= 400) begin
            fail_now("start_bit_wait");
            return;
        end
        c = 0;
        while (done_w[inst] !== 1'b1 && c < 256) begin
            line[c] = tx_w[inst];
            c++;
            @(negedge clk);
        end
        len = c;
        for (int b = 0; b < nb; b++) begin
            if (b * cpb + cpb / 2 < c) bits[b] = line[b * cpb + cpb / 2];
        end
    endtask

    logic [10:0] bits, bits2;
    int len, gap, len2, gap2, wcnt;

    initial begin
        rst = 1'b0;
        wr(0, 8'hA5);
        // Reset held with data waiting: outputs stay idle.
        repeat (5) @(negedge clk);
        chk("rst_tx", 32'(tx_w[0]), 32'd1);
        chk("rst_rd", 32'(rd_w[0]), 32'd0);
        chk("rst_busy", 32'(busy_w[0]), 32'd0);
        chk("rst_done", 32'(done_w[0]), 32'd0);
        @(posedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        chk("rel_rd_c1", 32'(rd_w[0]), 32'd0);
        @(negedge clk);
        chk("rel_rd_c2", 32'(rd_w[0]), 32'd1);
        chk("rel_busy_c2", 32'(busy_w[0]), 32'd1);

        // Single byte 0xA5.
        capture(0, 4, 10, bits, len, gap);
        chk("a5_bits", 32'(bits[9:0]), 32'h34A);
        chk("a5_len", 32'(len), 32'd40);
        chk("a5_latency", 32'(gap), 32'd2);
        chk("a5_busy_after", 32'(busy_w[0]), 32'd0);
        chk("a5_rd_count", 32'(rd_cnt[0]), 32'd1);

        // Back-to-back frames.
        wr(0, 8'h00);
        wr(0, 8'hFF);
        wr(0, 8'h3C);
        capture(0, 4, 10, bits, len, gap);
        chk("b2b0_data", 32'(bits[8:1]), 32'h00);
        chk("b2b0_len", 32'(len), 32'd40);
        chk("b2b0_busy", 32'(busy_w[0]), 32'd1);
        capture(0, 4, 10, bits, len, gap);
        chk("b2b1_data", 32'(bits[8:1]), 32'hFF);
        chk("b2b1_gap", 32'(gap), 32'd2);
        chk("b2b1_busy", 32'(busy_w[0]), 32'd1);
        capture(0, 4, 10, bits, len, gap);
        chk("b2b2_data", 32'(bits[8:1]), 32'h3C);
        chk("b2b2_gap", 32'(gap), 32'd2);
        chk("b2b2_stop", 32'(bits[9]), 32'd1);
        chk("b2b2_busy", 32'(busy_w[0]), 32'd0);
        chk("b2b_rd_count", 32'(rd_cnt[0]), 32'd4);
        chk("b2b_fifo_left", 32'(fq[0].size()), 32'd0);

        // Parity, even and odd, byte 0x07.
        wr(1, 8'h07);
        wr(2, 8'h07);
        fork
            capture(1, 4, 11, bits, len, gap);
            capture(2, 4, 11, bits2, len2, gap2);
        join
        chk("par_even_data", 32'(bits[8:1]), 32'h07);
        chk("par_even_bit", 32'(bits[9]), 32'd1);
        chk("par_even_stop", 32'(bits[10]), 32'd1);
        chk("par_even_len", 32'(len), 32'd44);
        chk("par_odd_bit", 32'(bits2[9]), 32'd0);
        chk("par_odd_len", 32'(len2), 32'd44);
        @(negedge clk);

        // Reset during data bit 3 of 0x5A.
        wr(0, 8'h5A);
        wcnt = 0;
        while (tx_w[0] !== 1'b0 && wcnt < 400) begin
            @(negedge clk);
            wcnt++;
        end
        if (wcnt >= 400) fail_now("mid_start_wait");
        repeat (17) @(negedge clk);
        chk("mid_tx_before", 32'(tx_w[0]), 32'(8'h5A >> 3) & 32'd1);
        #1 rst = 1'b0;
        #1;
        chk("mid_async_tx", 32'(tx_w[0]), 32'd1);
        chk("mid_async_busy", 32'(busy_w[0]), 32'd0);
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        repeat (20) @(negedge clk);
        chk("mid_idle_tx", 32'(tx_w[0]), 32'd1);
        chk("mid_rd_count", 32'(rd_cnt[0]), 32'd5);
        wr(0, 8'h81);
        capture(0, 4, 10, bits, len, gap);
        chk("post_rst_bits", 32'(bits[9:0]), 32'h302);
        chk("post_rst_len", 32'(len), 32'd40);

        // Fill the FIFO while frame 1 is in flight, minimum bit width.
        fork
            begin
                wr(3, 8'h01);
                wcnt = 0;
                while (busy_w[3] !== 1'b1 && wcnt < 50) begin
                    @(negedge clk);
                    wcnt++;
                end
                if (wcnt >= 50) fail_now("fill_busy_wait");
                for (int i = 2; i <= 8; i++) begin
                    @(posedge clk);
                    #2 wr(3, 8'(i));
                end
            end
            begin
                for (int i = 0; i < 8; i++) begin
                    capture(3, 2, 10, bits2, len2, gap2);
                    chk($sformatf("fill%0d_data", i), 32'(bits2[8:1]), 32'(i + 1));
                    chk($sformatf("fill%0d_len", i), 32'(len2), 32'd20);
                    if (i > 0) chk($sformatf("fill%0d_gap", i), 32'(gap2), 32'd2);
                end
            end
        join
        repeat (4) @(negedge clk);
        chk("fill_rd_count", 32'(rd_cnt[3]), 32'd8);
        chk("fill_busy_end", 32'(busy_w[3]), 32'd0);
        chk("par_rd_count", 32'(rd_cnt[1] + rd_cnt[2]), 32'd2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Absolute time bound.
    initial begin
        #200000;
        $display("FAIL global_timeout t=%0t: bench did not complete", $time);
        errors++;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1);
    end

endmodule

// File: doc/fifo_uart_tx.md
# fifo_uart_tx

Serial transmit stage that drains bytes from the synchronous 8-deep byte FIFO and shifts them out as asynchronous UART frames (start, 8 data LSB-first, optional parity, stop). It sits directly downstream of the FIFO: it drives the FIFO's read enable, samples the FIFO's registered read data, and owns the serial line. It issues exactly one read per frame and never reads while the FIFO reports empty.

## Interface
- CLKS_PER_BIT, 16: clk cycles per serial bit; legal range 2..65535.
- PARITY_EN, 0: 1 inserts a parity bit between the last data bit and stop.
- PARITY_ODD, 0: with PARITY_EN=1, 0 gives even parity and 1 gives odd parity.

- clk  in  1  rising-edge clock, shared with the FIFO.
- rst  in  1  reset, asynchronous, active-low.
- fifo_empty  in  1  FIFO empty flag.
- fifo_dout  in  8  FIFO read data, valid on the cycle after the read edge.
- fifo_rd_en  out  1  FIFO read strobe, one clk wide per byte.
- tx  out  1  serial line, idle high, registered.
- busy  out  1  high from the FETCH state until the frame's last stop cycle, inclusive.
- tx_done  out  1  one-clk pulse on the first cycle after the stop bit completes.

## Operation
- States: IDLE, FETCH, WAIT, START, DATA, PARITY, STOP.
- IDLE: tx=1. When fifo_empty=0 at an edge, go to FETCH.
- FETCH: fifo_rd_en=1 for this single cycle. The FIFO advances its read pointer at the closing edge. Go to WAIT.
- WAIT: fifo_dout now holds the byte. At the closing edge:
  - latch fifo_dout into the 8-bit shift register;
  - compute parity = XOR of the 8 bits, XOR PARITY_ODD;
  - drive tx=0 and go to START.
- START: holds tx=0 for CLKS_PER_BIT cycles, then tx=data[0] and go to DATA.
- DATA: shifts LSB-first. Bit index runs 0..7; each bit is held CLKS_PER_BIT cycles. After bit 7, go to PARITY (tx=parity) if PARITY_EN=1, otherwise go to STOP (tx=1).
- PARITY: holds the parity bit for CLKS_PER_BIT cycles, then go to STOP with tx=1.
- STOP: holds tx=1 for CLKS_PER_BIT cycles. At the end, tx_done pulses. If fifo_empty=0, go to FETCH; otherwise go to IDLE.
- Baud counter: 16 bits, counts 0..CLKS_PER_BIT-1 and is cleared on every state or bit change. A bit boundary occurs when the counter reaches CLKS_PER_BIT-1.
- fifo_rd_en is asserted only in FETCH. FETCH is entered only when fifo_empty=0 was sampled. No read is ever issued on an empty FIFO.
- fifo_dout is sampled only in WAIT. Changes on fifo_dout at any other time are ignored.
- New writes into the FIFO during a frame do not affect the frame in flight.

## Timing
- Reset (rst=0) immediately forces: tx=1, fifo_rd_en=0, busy=0, tx_done=0, state=IDLE, counters=0, shift register=0.
- Reset mid-frame:
  - tx returns high asynchronously and the partial frame is truncated.
  - A byte already read from the FIFO is lost.
  - After release, operation resumes from IDLE.
- Latency: fifo_empty falls before edge k. Then:
  - edge k: enter FETCH, fifo_rd_en=1;
  - edge k+1: enter WAIT;
  - edge k+2: tx falls (start bit).
- Frame length is exactly (10 + PARITY_EN) × CLKS_PER_BIT clk cycles, measured from the tx falling edge to the end of stop.
- Back-to-back frames: with the FIFO non-empty at the end of stop, the line stays high for the stop bit plus exactly 2 extra cycles (FETCH, WAIT) before the next start bit.
- busy:
  - rises at edge k, together with fifo_rd_en;
  - falls at the end of stop when the FIFO is empty;
  - stays high continuously across back-to-back frames.
- tx_done: high for exactly one cycle per completed frame, coincident with the first FETCH or IDLE cycle after stop.

## Test plan
- Reset: hold rst=0 with fifo_empty=0 → tx=1, fifo_rd_en=0, busy=0, tx_done=0 throughout. Release → fifo_rd_en pulses 2 cycles later.
- Single byte, CLKS_PER_BIT=4, PARITY_EN=0: FIFO holds 0xA5 → exactly one fifo_rd_en pulse. tx carries 0 start, then bits 1,0,1,0,0,1,0,1, then 1 stop, each bit 4 clk wide (40 clk total). tx_done pulses once; busy then drops.
- Back-to-back, CLKS_PER_BIT=4: FIFO holds 0x00, 0xFF, 0x3C → three frames, each separated by stop + 2 high cycles. Exactly 3 rd_en pulses. The FIFO ends empty and no rd_en is issued while fifo_empty=1.
- Parity: PARITY_EN=1, PARITY_ODD=0, byte 0x07 → parity bit 1. Same byte with PARITY_ODD=1 → parity bit 0. Frame length is 11 bit times.
- Reset mid-frame: assert rst=0 during data bit 3 of 0x5A → tx goes high asynchronously. After release with the FIFO empty, tx stays 1 and no rd_en is issued. A later write of 0x81 transmits a clean, full frame.
- Fill during transmit: 8 writes (0x01..0x08) arrive while frame 1 is in flight → 8 frames are transmitted in order. CLKS_PER_BIT=2 exercises the minimum legal bit width.
